reg_file_write_arbiter: RTL and testbench



---
 rtl/reg_file_write_arbiter_if.sv | 29 ++
 rtl/reg_file_write_arbiter.sv | 126 ++++++++++++
 tb/tb_reg_file_write_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_write_arbiter_if.sv
// Requester-side handshake and register-file write bus for reg_file_write_arbiter.
// The master modport is the requester/register-file side; slave is the arbiter.
interface reg_file_write_arbiter_if #(
  parameter int unsigned REGISTER_WIDTH = 32,
  parameter int unsigned NUM_REGISTERS  = 16,
  parameter int unsigned NUM_REQ        = 4
);
  localparam int unsigned ADDR_WIDTH  = $clog2(NUM_REGISTERS);
  localparam int unsigned GRANT_WIDTH = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]                      i_req_valid;
  logic [NUM_REQ-1:0]                      o_req_ready;
  logic [NUM_REQ*ADDR_WIDTH-1:0]           i_req_addr;
  logic [NUM_REQ*REGISTER_WIDTH-1:0]       i_req_data;
  logic [NUM_REGISTERS-1:0]                o_write_req;
  logic [NUM_REGISTERS*REGISTER_WIDTH-1:0] o_write_data;
  logic [GRANT_WIDTH-1:0]                  o_grant_idx;
  logic                                    o_busy;

  modport master (
    output i_req_valid, i_req_addr, i_req_data,
    input  o_req_ready, o_write_req, o_write_data, o_grant_idx, o_busy
  );

  modport slave (
    input  i_req_valid, i_req_addr, i_req_data,
    output o_req_ready, o_write_req, o_write_data, o_grant_idx, o_busy
  );
endinterface

// File: rtl/reg_file_write_arbiter.sv
// Round-robin write arbiter for the direct-access register file with a bounded burst lock.
// Define REG_ARB_ERR_EN to enable the sticky out-of-range error flag (o_err / i_err_clr).
module reg_file_write_arbiter #(
  parameter int unsigned REGISTER_WIDTH = 32,
  parameter int unsigned NUM_REGISTERS  = 16,
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned MAX_BURST      = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  reg_file_write_arbiter_if.slave bus,
  input  logic                    i_err_clr,
  output logic                    o_err
);
  localparam int unsigned ADDR_WIDTH  = $clog2(NUM_REGISTERS);
  localparam int unsigned GRANT_WIDTH = $clog2(NUM_REQ);
  localparam int unsigned BURST_WIDTH = $clog2(MAX_BURST + 1);
  localparam logic [BURST_WIDTH-1:0] BURST_MAX = BURST_WIDTH'(MAX_BURST);
  localparam logic [GRANT_WIDTH-1:0] LAST_REQ  = GRANT_WIDTH'(NUM_REQ - 1);

  logic [GRANT_WIDTH-1:0]                  rr_ptr, rr_ptr_d, owner, owner_d, winner, grant_q;
  logic [BURST_WIDTH-1:0]                  burst_cnt, burst_d;
  logic                                    lock, found, in_range, busy_q;
  logic [NUM_REQ-1:0]                      req_ready;
  logic [ADDR_WIDTH-1:0]                   acc_addr;
  logic [REGISTER_WIDTH-1:0]               acc_data;
  logic [NUM_REGISTERS-1:0]                write_req_d, write_req_q;
  logic [NUM_REGISTERS*REGISTER_WIDTH-1:0] write_data_d, write_data_q;

  // The owner keeps the grant while its burst is open; otherwise scan from rr_ptr.
  always_comb begin : select
    int unsigned idx;
    idx    = 0;
    lock   = bus.i_req_valid[owner] && (burst_cnt != '0) && (burst_cnt < BURST_MAX);
    found  = lock;
    winner = owner;
    if (!lock) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        idx = (32'(rr_ptr) + k) % NUM_REQ;
        if (!found && bus.i_req_valid[idx]) begin
          found  = 1'b1;
          winner = GRANT_WIDTH'(idx);
        end
      end
    end
    req_ready = '0;
    if (found) req_ready[winner] = 1'b1;
  end

  always_comb begin : datapath
    acc_addr     = bus.i_req_addr[32'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
    acc_data     = bus.i_req_data[32'(winner)*REGISTER_WIDTH +: REGISTER_WIDTH];
    in_range     = 32'(acc_addr) < NUM_REGISTERS;
    write_req_d  = '0;
    write_data_d = '0;
    if (found && in_range) begin
      write_req_d[acc_addr] = 1'b1;
      write_data_d[32'(acc_addr)*REGISTER_WIDTH +: REGISTER_WIDTH] = acc_data;
    end
  end

  // An owner that drops valid without anyone being accepted loses its open burst.
  always_comb begin : next_state
    rr_ptr_d = rr_ptr;
    owner_d  = owner;
    burst_d  = burst_cnt;
    if (found) begin
      if (lock) begin
        burst_d = burst_cnt + 1'b1;
      end else begin
        owner_d = winner;
        burst_d = BURST_WIDTH'(1);
      end
      rr_ptr_d = (winner == LAST_REQ) ? '0 : winner + 1'b1;
    end else if (!bus.i_req_valid[owner]) begin
      burst_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr       <= '0;
      owner        <= '0;
      burst_cnt    <= '0;
      grant_q      <= '0;
      busy_q       <= 1'b0;
      write_req_q  <= '0;
      write_data_q <= '0;
    end else begin
      rr_ptr       <= rr_ptr_d;
      owner        <= owner_d;
      burst_cnt    <= burst_d;
      busy_q       <= found && in_range;
      write_req_q  <= write_req_d;
      write_data_q <= write_data_d;
      if (found) grant_q <= winner;
    end
  end

  assign bus.o_req_ready  = req_ready;
  assign bus.o_write_req  = write_req_q;
  assign bus.o_write_data = write_data_q;
  assign bus.o_grant_idx  = grant_q;
  assign bus.o_busy       = busy_q;

`ifdef REG_ARB_ERR_EN
  logic err_q;

  // A new out-of-range accept takes priority over a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (found && !in_range) begin
      err_q <= 1'b1;
    end else if (i_err_clr) begin
      err_q <= 1'b0;
    end
  end

  assign o_err = err_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = i_err_clr;
  assign o_err          = 1'b0;
`endif
endmodule

// File: tb/tb_reg_file_write_arbiter.sv
// Bench for reg_file_write_arbiter: dut_a uses 16 registers / MAX_BURST 4, dut_b 12 registers / MAX_BURST 1.
// Expected values come from a cycle-level model of the arbitration rules kept in integer state.
module tb_reg_file_write_arbiter;
  localparam int NREQ = 4;
  localparam int RW   = 32;
  localparam int AW   = 4;
  localparam int NR_A = 16;
  localparam int NR_B = 12;
  localparam int MB_A = 4;
  localparam int MB_B = 1;
`ifdef REG_ARB_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic err_clr = 1'b0;
  logic err_a, err_b;
  always #5 clk = ~clk;

  reg_file_write_arbiter_if #(.REGISTER_WIDTH(RW), .NUM_REGISTERS(NR_A), .NUM_REQ(NREQ)) bus_a ();
  reg_file_write_arbiter_if #(.REGISTER_WIDTH(RW), .NUM_REGISTERS(NR_B), .NUM_REQ(NREQ)) bus_b ();

  reg_file_write_arbiter #(.REGISTER_WIDTH(RW), .NUM_REGISTERS(NR_A), .NUM_REQ(NREQ), .MAX_BURST(MB_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.slave), .i_err_clr(err_clr), .o_err(err_a));
  reg_file_write_arbiter #(.REGISTER_WIDTH(RW), .NUM_REGISTERS(NR_B), .NUM_REQ(NREQ), .MAX_BURST(MB_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.slave), .i_err_clr(err_clr), .o_err(err_b));

  int checks = 0;
  int passes = 0;

  // stimulus per DUT
  logic [NREQ-1:0] v  [2];
  logic [AW-1:0]   ad [2][NREQ];
  logic [RW-1:0]   dt [2][NREQ];

  // model state per DUT
  int mb [2] = '{MB_A, MB_B};
  int nr [2] = '{NR_A, NR_B};
  int m_rr [2], m_owner [2], m_burst [2], m_slot [2], m_grant [2];
  logic [RW-1:0] m_data [2];
  bit m_err [2];

  // per-tick observations and expectations
  int acc_w [2];
  logic [NREQ-1:0] obs_ready [2], exp_ready [2];
  logic [NR_A-1:0] obs_wreq [2], exp_wreq [2];
  logic [NR_A*RW-1:0] obs_wdata [2], exp_wdata [2];
  int obs_grant [2], exp_grant [2];
  logic obs_busy [2], exp_busy [2], obs_err [2], exp_err [2];

  task automatic drive();
    bus_a.i_req_valid = v[0];
    bus_b.i_req_valid = v[1];
    for (int k = 0; k < NREQ; k++) begin
      bus_a.i_req_addr[k*AW +: AW] = ad[0][k];
      bus_b.i_req_addr[k*AW +: AW] = ad[1][k];
      bus_a.i_req_data[k*RW +: RW] = dt[0][k];
      bus_b.i_req_data[k*RW +: RW] = dt[1][k];
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_rr[d] = 0; m_owner[d] = 0; m_burst[d] = 0;
      m_slot[d] = -1; m_grant[d] = 0; m_data[d] = '0; m_err[d] = 1'b0;
    end
  endtask

  function automatic int pick(int d);
    if (v[d][m_owner[d]] && m_burst[d] > 0 && m_burst[d] < mb[d]) return m_owner[d];
    for (int k = 0; k < NREQ; k++)
      if (v[d][(m_rr[d] + k) % NREQ]) return (m_rr[d] + k) % NREQ;
    return -1;
  endfunction

  // One cycle: apply inputs after the falling edge, observe, then advance the model to the next edge.
  task automatic tick();
    @(negedge clk);
    drive();
    #1;
    for (int d = 0; d < 2; d++) begin
      exp_wreq[d] = '0;
      exp_wdata[d] = '0;
      if (m_slot[d] >= 0) begin
        exp_wreq[d][m_slot[d]] = 1'b1;
        exp_wdata[d][m_slot[d]*RW +: RW] = m_data[d];
      end
      exp_busy[d]  = (m_slot[d] >= 0);
      exp_grant[d] = m_grant[d];
      exp_err[d]   = m_err[d];
      acc_w[d]     = pick(d);
      exp_ready[d] = '0;
      if (acc_w[d] >= 0) exp_ready[d][acc_w[d]] = 1'b1;
    end
    obs_ready[0] = bus_a.o_req_ready;          obs_ready[1] = bus_b.o_req_ready;
    obs_wreq[0]  = bus_a.o_write_req;          obs_wreq[1]  = 16'(bus_b.o_write_req);
    obs_wdata[0] = bus_a.o_write_data;         obs_wdata[1] = (NR_A*RW)'(bus_b.o_write_data);
    obs_grant[0] = int'(bus_a.o_grant_idx);    obs_grant[1] = int'(bus_b.o_grant_idx);
    obs_busy[0]  = bus_a.o_busy;               obs_busy[1]  = bus_b.o_busy;
    obs_err[0]   = err_a;                      obs_err[1]   = err_b;
    for (int d = 0; d < 2; d++) begin
      bit set_err;
      int w;
      set_err = 1'b0;
      w = acc_w[d];
      if (w >= 0) begin
        if (w == m_owner[d] && m_burst[d] > 0 && m_burst[d] < mb[d]) m_burst[d]++;
        else begin m_owner[d] = w; m_burst[d] = 1; end
        m_rr[d] = (w + 1) % NREQ;
        m_grant[d] = w;
        if (int'(ad[d][w]) < nr[d]) begin m_slot[d] = int'(ad[d][w]); m_data[d] = dt[d][w]; end
        else begin m_slot[d] = -1; set_err = 1'b1; end
      end else begin
        m_slot[d] = -1;
        if (!v[d][m_owner[d]]) m_burst[d] = 0;
      end
      if (ERR_ON) begin
        if (set_err) m_err[d] = 1'b1;
        else if (err_clr) m_err[d] = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    err_clr = 1'b0;
    for (int d = 0; d < 2; d++) v[d] = '0;
    drive();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      v[d] = '0;
      for (int k = 0; k < NREQ; k++) begin ad[d][k] = '0; dt[d][k] = '0; end
    end
    drive();
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus_a.o_write_req !== 16'h0) $display("FAIL reset_wreq: got %h expected 0", bus_a.o_write_req); else passes++;
    checks++; if (bus_a.o_write_data !== '0) $display("FAIL reset_wdata: got %h expected 0", bus_a.o_write_data); else passes++;
    checks++; if (bus_a.o_grant_idx !== 2'd0) $display("FAIL reset_grant: got %0d expected 0", bus_a.o_grant_idx); else passes++;
    checks++; if (bus_a.o_busy !== 1'b0 || bus_b.o_busy !== 1'b0) $display("FAIL reset_busy: got %b%b expected 00", bus_a.o_busy, bus_b.o_busy); else passes++;
    checks++; if (err_a !== 1'b0 || err_b !== 1'b0) $display("FAIL reset_err: got %b%b expected 00", err_a, err_b); else passes++;
    rst_n = 1'b1;
  endtask

  task automatic test_single_write();
    do_reset();
    v[0] = 4'b0010; ad[0][1] = 4'd3; dt[0][1] = 32'hDEADBEEF;
    tick();
    checks++; if (obs_ready[0] !== 4'b0010) $display("FAIL single_ready: got %b expected 0010", obs_ready[0]); else passes++;
    v[0] = '0;
    tick();
    checks++; if (obs_wreq[0] !== 16'h0008) $display("FAIL single_wreq: got %h expected 0008", obs_wreq[0]); else passes++;
    checks++; if (obs_wdata[0][3*RW +: RW] !== 32'hDEADBEEF || obs_wdata[0] !== exp_wdata[0])
      $display("FAIL single_wdata: got %h expected %h", obs_wdata[0], exp_wdata[0]); else passes++;
    checks++; if (obs_grant[0] !== 1 || obs_busy[0] !== 1'b1) $display("FAIL single_grant_busy: got %0d/%b expected 1/1", obs_grant[0], obs_busy[0]); else passes++;
    tick();
    checks++; if (obs_wreq[0] !== 16'h0 || obs_busy[0] !== 1'b0 || obs_wdata[0] !== '0)
      $display("FAIL single_idle: got wreq %h busy %b expected 0 0", obs_wreq[0], obs_busy[0]); else passes++;
  endtask

  task automatic test_round_robin();
    do_reset();
    v[1] = 4'hF;
    for (int k = 0; k < NREQ; k++) begin ad[1][k] = 4'($urandom_range(11, 0)); dt[1][k] = $urandom; end
    for (int i = 0; i < 9; i++) begin
      tick();
      checks++; if (obs_ready[1] !== 4'(1 << (i % 4))) $display("FAIL rr_order[%0d]: got %b expected %b", i, obs_ready[1], 4'(1 << (i % 4))); else passes++;
      if (i > 0) begin
        checks++; if (obs_wreq[1] !== exp_wreq[1] || obs_wdata[1] !== exp_wdata[1] || obs_busy[1] !== 1'b1)
          $display("FAIL rr_strobe[%0d]: got %h expected %h", i, obs_wreq[1], exp_wreq[1]); else passes++;
      end
      ad[1][i % 4] = 4'($urandom_range(11, 0));
      dt[1][i % 4] = $urandom;
    end
    v[1] = '0;
  endtask

  task automatic test_burst_lock();
    do_reset();
    v[0] = 4'hF;
    for (int k = 0; k < NREQ; k++) begin ad[0][k] = 4'($urandom); dt[0][k] = $urandom; end
    for (int i = 0; i < 17; i++) begin
      tick();
      checks++; if (obs_ready[0] !== 4'(1 << ((i / 4) % 4))) $display("FAIL burst_order[%0d]: got %b expected %b", i, obs_ready[0], 4'(1 << ((i / 4) % 4))); else passes++;
      if (i > 0) begin
        checks++; if (obs_grant[0] !== ((i - 1) / 4) % 4 || obs_wreq[0] !== exp_wreq[0] || obs_wdata[0] !== exp_wdata[0])
          $display("FAIL burst_strobe[%0d]: got grant %0d wreq %h expected %0d %h", i, obs_grant[0], obs_wreq[0], ((i - 1) / 4) % 4, exp_wreq[0]); else passes++;
      end
      ad[0][(i / 4) % 4] = 4'($urandom);
    end
    v[0] = '0;
  endtask

  task automatic test_owner_drop();
    do_reset();
    v[0] = 4'b0100;
    repeat (2) tick();
    v[0] = 4'b1001;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (obs_ready[0] !== ((i < 4) ? 4'b1000 : 4'b0001))
        $display("FAIL drop_order[%0d]: got %b expected %b", i, obs_ready[0], (i < 4) ? 4'b1000 : 4'b0001); else passes++;
    end
    v[0] = '0;
  endtask

  task automatic test_out_of_range();
    do_reset();
    v[1] = 4'b0010; ad[1][1] = 4'd13; dt[1][1] = 32'h1234_5678;
    tick();
    checks++; if (obs_ready[1] !== 4'b0010) $display("FAIL oor_ready: got %b expected 0010", obs_ready[1]); else passes++;
    v[1] = '0;
    tick();
    checks++; if (obs_wreq[1] !== 16'h0 || obs_busy[1] !== 1'b0) $display("FAIL oor_no_strobe: got %h/%b expected 0/0", obs_wreq[1], obs_busy[1]); else passes++;
    checks++; if (obs_err[1] !== ERR_ON) $display("FAIL oor_err_set: got %b expected %b", obs_err[1], ERR_ON); else passes++;
    tick();
    checks++; if (obs_err[1] !== ERR_ON) $display("FAIL oor_err_sticky: got %b expected %b", obs_err[1], ERR_ON); else passes++;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    tick();
    checks++; if (obs_err[1] !== 1'b0) $display("FAIL oor_err_clr: got %b expected 0", obs_err[1]); else passes++;
    v[1] = 4'b0010; err_clr = 1'b1;
    tick();
    v[1] = '0; err_clr = 1'b0;
    tick();
    checks++; if (obs_err[1] !== ERR_ON) $display("FAIL oor_set_wins: got %b expected %b", obs_err[1], ERR_ON); else passes++;
    v[1] = 4'b0001; ad[1][0] = 4'd11; dt[1][0] = 32'hCAFE_F00D;
    tick();
    v[1] = '0;
    tick();
    checks++; if (obs_wreq[1] !== 16'h0800 || obs_wdata[1][11*RW +: RW] !== 32'hCAFE_F00D || obs_busy[1] !== 1'b1)
      $display("FAIL top_reg_write: got %h/%b expected 0800/1", obs_wreq[1], obs_busy[1]); else passes++;
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    v[0] = 4'b1010; ad[0][1] = 4'd5; dt[0][1] = 32'hA5A5_5A5A;
    tick();
    checks++; if (obs_ready[0] !== 4'b0010) $display("FAIL midrst_ready: got %b expected 0010", obs_ready[0]); else passes++;
    rst_n = 1'b0;
    v[0] = '0;
    drive();
    model_reset();
    @(negedge clk);
    #1;
    checks++; if (bus_a.o_write_req !== 16'h0 || bus_a.o_write_data !== '0 || bus_a.o_busy !== 1'b0 || bus_a.o_grant_idx !== 2'd0)
      $display("FAIL midrst_outputs: got wreq %h busy %b grant %0d expected 0", bus_a.o_write_req, bus_a.o_busy, bus_a.o_grant_idx); else passes++;
    rst_n = 1'b1;
    v[0] = 4'b1100; ad[0][2] = 4'd9;
    tick();
    checks++; if (obs_wreq[0] !== 16'h0) $display("FAIL midrst_no_strobe: got %h expected 0", obs_wreq[0]); else passes++;
    checks++; if (obs_ready[0] !== 4'b0100) $display("FAIL midrst_first_grant: got %b expected 0100", obs_ready[0]); else passes++;
    v[0] = '0;
    tick();
    checks++; if (obs_grant[0] !== 2 || obs_wreq[0] !== 16'h0200) $display("FAIL midrst_write: got %0d/%h expected 2/0200", obs_grant[0], obs_wreq[0]); else passes++;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      err_clr = ($urandom % 6 == 0);
      tick();
      for (int d = 0; d < 2; d++) begin
        checks++; if (obs_ready[d] !== exp_ready[d]) $display("FAIL rnd_ready d%0d c%0d: got %b expected %b", d, i, obs_ready[d], exp_ready[d]); else passes++;
        checks++; if (obs_wreq[d] !== exp_wreq[d]) $display("FAIL rnd_wreq d%0d c%0d: got %h expected %h", d, i, obs_wreq[d], exp_wreq[d]); else passes++;
        checks++; if (obs_wdata[d] !== exp_wdata[d]) $display("FAIL rnd_wdata d%0d c%0d: got %h expected %h", d, i, obs_wdata[d], exp_wdata[d]); else passes++;
        checks++; if (obs_grant[d] !== exp_grant[d]) $display("FAIL rnd_grant d%0d c%0d: got %0d expected %0d", d, i, obs_grant[d], exp_grant[d]); else passes++;
        checks++; if (obs_busy[d] !== exp_busy[d]) $display("FAIL rnd_busy d%0d c%0d: got %b expected %b", d, i, obs_busy[d], exp_busy[d]); else passes++;
        checks++; if (obs_err[d] !== exp_err[d]) $display("FAIL rnd_err d%0d c%0d: got %b expected %b", d, i, obs_err[d], exp_err[d]); else passes++;
        for (int k = 0; k < NREQ; k++) begin
          if (k == acc_w[d]) v[d][k] = 1'b0;
          else if (v[d][k] && ($urandom % 16 == 0)) v[d][k] = 1'b0;
          if (!v[d][k] && k != acc_w[d] && ($urandom % 2 == 0)) begin
            v[d][k] = 1'b1; ad[d][k] = 4'($urandom); dt[d][k] = $urandom;
          end else if (k == acc_w[d] && ($urandom % 2 == 0)) begin
            v[d][k] = 1'b1; ad[d][k] = 4'($urandom); dt[d][k] = $urandom;
          end
        end
      end
    end
    err_clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_burst_lock();
    test_owner_drop();
    test_out_of_range();
    test_reset_mid_op();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
